// File: rtl/bms_pkg.sv
// Shared constants and state encoding for the per-cell coulomb counter.
package bms_pkg;
   localparam int CELLS = 4;
   localparam logic [31:0] FP_ZERO = 32'h00000000;
   localparam logic [31:0] FP_ONE  = 32'h3F800000;
   localparam int FP_BIAS = 127;

   typedef enum logic {
      IDLE = 1'b0,
      CONV = 1'b1
   } state_t;
endpackage

// File: rtl/coulomb_counter_if.sv
// Sample/preset strobes in, SOC floats and status flags out.
interface coulomb_counter_if #(parameter int CAP_LOG2 = 24);
   logic                sample_valid;
   logic [31:0]         I1, I2, I3, I4;
   logic                load_en;
   logic [CAP_LOG2:0]   load_charge;
   logic [31:0]         soc1, soc2, soc3, soc4;
   logic                soc_valid;
   logic                busy;
   logic                overrun;
   logic [3:0]          full;
   logic [3:0]          empty;

   modport master (
      output sample_valid, I1, I2, I3, I4, load_en, load_charge,
      input  soc1, soc2, soc3, soc4, soc_valid, busy, overrun, full, empty
   );
   modport slave (
      input  sample_valid, I1, I2, I3, I4, load_en, load_charge,
      output soc1, soc2, soc3, soc4, soc_valid, busy, overrun, full, empty
   );
endinterface

// File: rtl/fix_to_float.sv
// Unsigned charge (scaled by 2^-CAP_LOG2) to IEEE-754 single, truncating extra LSBs.
module fix_to_float
   import bms_pkg::*;
#(
   parameter int CAP_LOG2 = 24
) (
   input  logic [CAP_LOG2:0] charge,
   output logic [31:0]       f
);
   logic [5:0]           p;
   logic [CAP_LOG2:0]    norm;
   logic [CAP_LOG2+22:0] wide;

   always_comb begin
      p = '0;
      for (int i = 0; i <= CAP_LOG2; i++)
         if (charge[i]) p = 6'(i);
      // shift MSB to the top, then pad so short fractions still fill 23 bits
      norm = charge << (6'(CAP_LOG2) - p);
      wide = {norm[CAP_LOG2-1:0], 23'd0};
      if (charge == '0)
         f = FP_ZERO;
      else
         f = {1'b0, 8'(FP_BIAS + int'(p) - CAP_LOG2), wide[CAP_LOG2+22 -: 23]};
   end
endmodule

// File: rtl/coulomb_counter.sv
// Four-cell coulomb counter; COULOMB_EFF_EN scales charging currents by 15/16.
module coulomb_counter
   import bms_pkg::*;
#(
   parameter int CAP_LOG2 = 24
) (
   input  logic              clk,
   input  logic              rst_n,
   coulomb_counter_if.slave  bus
);
   localparam logic [CAP_LOG2:0] CAP = {1'b1, {CAP_LOG2{1'b0}}};

   state_t                        state;
   logic [1:0]                    idx;
   logic [CELLS-1:0][CAP_LOG2:0]  charge, charge_acc;
   logic [CELLS-1:0][31:0]        cur, soc_q;
   logic [CAP_LOG2:0]             load_val;
   logic [31:0]                   conv;
   logic                          soc_valid_q, overrun_q;

   assign cur      = {bus.I4, bus.I3, bus.I2, bus.I1};
   assign load_val = (bus.load_charge > CAP) ? CAP : bus.load_charge;

   for (genvar k = 0; k < CELLS; k++) begin : g_acc
      logic signed [33:0] ext, delta, sum;
      logic [CAP_LOG2:0]  nxt;
      always_comb begin
         ext = {{2{cur[k][31]}}, cur[k]};
`ifdef COULOMB_EFF_EN
         delta = ext[33] ? ext : ext - (ext >>> 4);
`else
         delta = ext;
`endif
         sum = $signed({{(33-CAP_LOG2){1'b0}}, charge[k]}) + delta;
         if (sum < 0)
            nxt = '0;
         else if (sum > $signed({{(33-CAP_LOG2){1'b0}}, CAP}))
            nxt = CAP;
         else
            nxt = sum[CAP_LOG2:0];
      end
      assign charge_acc[k] = nxt;
   end

   always_comb begin
      bus.full  = '0;
      bus.empty = '0;
      for (int k = 0; k < CELLS; k++) begin
         bus.full[k]  = (charge[k] == CAP);
         bus.empty[k] = (charge[k] == '0);
      end
   end

   fix_to_float #(.CAP_LOG2(CAP_LOG2)) u_f2f (
      .charge (charge[idx]),
      .f      (conv)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         idx         <= '0;
         charge      <= '0;
         soc_q       <= {CELLS{FP_ZERO}};
         soc_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         soc_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.load_en) begin
                  charge <= {CELLS{load_val}};
                  state  <= CONV;
                  idx    <= '0;
               end else if (bus.sample_valid) begin
                  charge <= charge_acc;
                  state  <= CONV;
                  idx    <= '0;
               end
            end
            CONV: begin
               soc_q[idx] <= conv;
               idx        <= idx + 2'd1;
               if (idx == 2'd3) begin
                  state       <= IDLE;
                  soc_valid_q <= 1'b1;
               end
               if (bus.load_en || bus.sample_valid) overrun_q <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.soc1      = soc_q[0];
   assign bus.soc2      = soc_q[1];
   assign bus.soc3      = soc_q[2];
   assign bus.soc4      = soc_q[3];
   assign bus.soc_valid = soc_valid_q;
   assign bus.overrun   = overrun_q;
   assign bus.busy      = (state == CONV);
endmodule

// File: doc/coulomb_counter.md
Name: coulomb_counter

Overview:
- Per-cell state-of-charge (SOC) estimator: integrates the four sensed cell currents each sample and produces soc1..soc4.
- Outputs are IEEE-754 single values in 0.0..1.0 that feed the current-distribution datapath directly.
- Closes the BMS loop: the datapath turns SOC into cell currents; this block turns cell currents back into SOC.
- Internal charge is unsigned fixed point; a single shared fixed-to-float converter is time-multiplexed across the four cells.

Parameters:
- CAP_LOG2, 24: full-cell charge = 2^CAP_LOG2 current-LSB·samples. Legal range 8..30.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- sample_valid  in  1  one-cycle strobe; I1..I4 valid this cycle
- I1, I2, I3, I4  in  32 each  signed two's-complement cell currents; positive = charging
- load_en  in  1  one-cycle strobe; preset all cell charges
- load_charge  in  CAP_LOG2+1  preset value, clamped to 2^CAP_LOG2
- soc1, soc2, soc3, soc4  out  32 each  IEEE-754 SOC
- soc_valid  out  1  one-cycle pulse when all four SOC outputs are coherent
- busy  out  1  high while state != IDLE
- overrun  out  1  one-cycle pulse when sample_valid or load_en arrives while busy
- full  out  4  bit k-1 = cell k charge equals 2^CAP_LOG2
- empty  out  4  bit k-1 = cell k charge equals 0

Behaviour:
- Reset (asynchronous, takes effect at any time including mid-CONV):
  - charges = 0, state = IDLE, idx = 0.
  - soc1..soc4 = 0x00000000; soc_valid, busy and overrun = 0.
  - full = 0000, empty = 1111.
- State machine: IDLE, CONV.
- IDLE, load_en = 1 (load_en has priority over sample_valid):
  - all charges := min(load_charge, 2^CAP_LOG2).
  - go to CONV with idx = 0; any simultaneous sample is discarded without an overrun pulse.
- IDLE, sample_valid = 1:
  - for each k in parallel: charge_k := clamp(charge_k + sext(I_k), 0, 2^CAP_LOG2).
  - The sum is computed in 34-bit signed arithmetic.
  - Go to CONV with idx = 0.
- CONV:
  - Each edge converts charge[idx] into soc[idx] and increments idx.
  - On the edge that converts idx = 3: go to IDLE, and soc_valid = 1 for exactly the following cycle.
- Latency: strobe sampled at edge 0; soc1..soc4 written at edges 1..4; soc_valid high during the cycle after edge 4. A new strobe is accepted on edge 5 at the earliest.
- Intermediate outputs: soc outputs update one per cycle during CONV and are coherent only when soc_valid = 1 or busy = 0.
- Strobe while busy: any strobe is ignored, charges are unchanged, and overrun pulses for 1 cycle.
- Conversion (value = charge · 2^-CAP_LOG2):
  - charge = 0 gives 0x00000000.
  - Otherwise p = MSB index; sign = 0; exponent = 127 + p − CAP_LOG2.
  - Mantissa = the bits below the MSB, left-aligned to 23 bits; extra LSBs truncate (round toward zero).
  - charge = 2^CAP_LOG2 gives exactly 0x3F800000.
- Flags: full and empty are decoded combinationally from the charge registers, so they are valid right after the accumulate edge.

Optional Feature:
- Macro: COULOMB_EFF_EN.
- Defined: positive (charging) currents are scaled by 15/16 before accumulation, computed as I − (I >>> 4) on the sign-extended value. Models coulombic efficiency. Negative currents pass unscaled.
- Undefined: all currents are accumulated unscaled.

Decomposition:
- Package bms_pkg holds:
  - CELLS = 4
  - FP_ZERO = 32'h00000000, FP_ONE = 32'h3F800000
  - FP_BIAS = 127
  - state encoding: IDLE = 1'b0, CONV = 1'b1
- One sub-module, fix_to_float: purely combinational.
  - Inputs: unsigned CAP_LOG2+1-bit charge. Output: 32-bit float.
  - Contains a priority encoder and a shifter.
  - Instantiated once and muxed by idx.

Test Plan (CAP_LOG2 = 24):
- Reset → soc1..soc4 = 0x00000000, empty = 1111, full = 0000, busy = 0, and soc_valid stays 0 until a strobe.
- load_en with load_charge = 2^23 → busy for 4 cycles; soc_valid pulses in cycle 5; all socs = 0x3F000000.
- After that load, sample with I1 = +2^22, I2 = −2^22, I3 = 0, I4 = +2^24 → socs = 0x3F400000, 0x3E800000, 0x3F000000, 0x3F800000; full = 1000.
- Sample with I1 = −2^25 from half charge → charge clamps to 0; soc1 = 0x00000000; empty[0] = 1.
- sample_valid two cycles after an accepted sample → overrun pulses once; the final socs reflect only the first sample.
- Assert rst_n low during CONV (idx = 2) → all outputs go to reset values immediately, with no soc_valid pulse.
- With COULOMB_EFF_EN: from zero charge, I1 = +16 → charge 15 → soc1 = 0x35700000.
